// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ==========================================================================
// id_ex_reg_if : ID-side inputs and EX-side outputs of the ID/EX register
// Revision 1.0
// ==========================================================================
interface id_ex_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [ADDR_WIDTH-1:0] i_rs1_addr;
  logic [ADDR_WIDTH-1:0] i_rs2_addr;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic [DATA_WIDTH-1:0] i_rs1_data;
  logic [DATA_WIDTH-1:0] i_rs2_data;
  logic [CTRL_WIDTH-1:0] i_ctrl;
  logic                  i_wb_wen;
  logic [ADDR_WIDTH-1:0] i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;

  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_pc;
  logic [DATA_WIDTH-1:0] o_imm;
  logic [ADDR_WIDTH-1:0] o_rs1_addr;
  logic [ADDR_WIDTH-1:0] o_rs2_addr;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic [DATA_WIDTH-1:0] o_rs1_data;
  logic [DATA_WIDTH-1:0] o_rs2_data;
  logic [CTRL_WIDTH-1:0] o_ctrl;
  logic [CNT_WIDTH-1:0]  o_stall_cnt;
  logic [CNT_WIDTH-1:0]  o_flush_cnt;

  modport master (
    output i_stall, i_flush, i_valid, i_pc, i_imm, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_rs1_data, i_rs2_data, i_ctrl, i_wb_wen, i_wb_addr, i_wb_data,
    input  o_valid, o_pc, o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_rs1_data, o_rs2_data, o_ctrl, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_pc, i_imm, i_rs1_addr, i_rs2_addr, i_rd_addr,
           i_rs1_data, i_rs2_data, i_ctrl, i_wb_wen, i_wb_addr, i_wb_data,
    output o_valid, o_pc, o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr,
           o_rs1_data, o_rs2_data, o_ctrl, o_stall_cnt, o_flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ==========================================================================
// id_ex_reg : ID/EX pipeline register with WB bypass, stall/flush, counters
// Revision 1.0
// ==========================================================================
module id_ex_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        i_rst_n,
  id_ex_reg_if.slave  bus
);

  logic                  valid_q,    valid_d;
  logic [DATA_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] imm_q,      imm_d;
  logic [ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
  logic [ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q,     ctrl_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  // x0 writes never forward; the regfile ignores them too.
  logic wb_live;
  assign wb_live = bus.i_wb_wen && (bus.i_wb_addr != '0);

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    ctrl_d     = ctrl_q;
    if (bus.i_flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      imm_d      = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      ctrl_d     = '0;
    end else if (bus.i_stall) begin
      // A held instruction must still see WB values that retire while it waits.
      if (valid_q && wb_live && (bus.i_wb_addr == rs1_addr_q)) rs1_data_d = bus.i_wb_data;
      if (valid_q && wb_live && (bus.i_wb_addr == rs2_addr_q)) rs2_data_d = bus.i_wb_data;
    end else begin
      valid_d    = bus.i_valid;
      pc_d       = bus.i_pc;
      imm_d      = bus.i_imm;
      rs1_addr_d = bus.i_rs1_addr;
      rs2_addr_d = bus.i_rs2_addr;
      rd_addr_d  = bus.i_rd_addr;
      ctrl_d     = bus.i_valid ? bus.i_ctrl : '0;
      if (bus.i_rs1_addr == '0)                           rs1_data_d = '0;
      else if (wb_live && (bus.i_wb_addr == bus.i_rs1_addr)) rs1_data_d = bus.i_wb_data;
      else                                                 rs1_data_d = bus.i_rs1_data;
      if (bus.i_rs2_addr == '0)                           rs2_data_d = '0;
      else if (wb_live && (bus.i_wb_addr == bus.i_rs2_addr)) rs2_data_d = bus.i_wb_data;
      else                                                 rs2_data_d = bus.i_rs2_data;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.i_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (bus.i_stall && !bus.i_flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_imm       = imm_q;
  assign bus.o_rs1_addr  = rs1_addr_q;
  assign bus.o_rs2_addr  = rs2_addr_q;
  assign bus.o_rd_addr   = rd_addr_q;
  assign bus.o_rs1_data  = rs1_data_q;
  assign bus.o_rs2_data  = rs2_data_q;
  assign bus.o_ctrl      = ctrl_q;
  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ==========================================================================
// tb_id_ex_reg : directed self-checking bench for id_ex_reg (CNT_WIDTH=4)
// Revision 1.0
// ==========================================================================
module tb_id_ex_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int NW = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

  id_ex_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_stall = 0; bus.i_flush = 0; bus.i_valid = 0;
    bus.i_pc = '0; bus.i_imm = '0;
    bus.i_rs1_addr = '0; bus.i_rs2_addr = '0; bus.i_rd_addr = '0;
    bus.i_rs1_data = '0; bus.i_rs2_data = '0; bus.i_ctrl = '0;
    bus.i_wb_wen = 0; bus.i_wb_addr = '0; bus.i_wb_data = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // 1. reset with toggling inputs
    for (int i = 0; i < 4; i++) begin
      bus.i_stall = 1'($urandom); bus.i_flush = 1'($urandom); bus.i_valid = 1'($urandom);
      bus.i_pc = $urandom; bus.i_imm = $urandom;
      bus.i_rs1_addr = 5'($urandom); bus.i_rs2_addr = 5'($urandom); bus.i_rd_addr = 5'($urandom);
      bus.i_rs1_data = $urandom; bus.i_rs2_data = $urandom; bus.i_ctrl = 16'($urandom);
      bus.i_wb_wen = 1'($urandom); bus.i_wb_addr = 5'($urandom); bus.i_wb_data = $urandom;
      tick();
    end
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_pc", bus.o_pc, 32'd0);
    chk("rst_rs1_data", bus.o_rs1_data, 32'd0);
    chk("rst_rs2_data", bus.o_rs2_data, 32'd0);
    chk("rst_ctrl", {16'd0, bus.o_ctrl}, 32'd0);
    chk("rst_rd", {27'd0, bus.o_rd_addr}, 32'd0);
    chk("rst_stall_cnt", {28'd0, bus.o_stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {28'd0, bus.o_flush_cnt}, 32'd0);

    idle_inputs();
    #2 rst_n = 1'b1;
    bus.i_valid = 1; bus.i_pc = 32'h100; bus.i_rs1_addr = 5'd1; bus.i_rs1_data = 32'h11;
    bus.i_imm = 32'hFFFF_FFF0; bus.i_ctrl = 16'h0A0A;
    tick();
    chk("load_pc", bus.o_pc, 32'h100);
    chk("load_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("load_rs1", bus.o_rs1_data, 32'h11);
    chk("load_imm", bus.o_imm, 32'hFFFF_FFF0);
    chk("load_ctrl", {16'd0, bus.o_ctrl}, 32'h0A0A);

    // 2. WB bypass
    bus.i_rs1_addr = 5'd5; bus.i_rs1_data = 32'hAAAA;
    bus.i_wb_wen = 1; bus.i_wb_addr = 5'd5; bus.i_wb_data = 32'h1234;
    tick();
    chk("byp_hit", bus.o_rs1_data, 32'h1234);
    bus.i_wb_addr = 5'd6;
    tick();
    chk("byp_miss", bus.o_rs1_data, 32'hAAAA);
    bus.i_wb_wen = 0; bus.i_wb_addr = 5'd5;
    tick();
    chk("byp_nowen", bus.o_rs1_data, 32'hAAAA);
    bus.i_wb_wen = 1; bus.i_wb_addr = 5'd0; bus.i_rs1_addr = 5'd0;
    tick();
    chk("byp_x0", bus.o_rs1_data, 32'd0);

    // 3. stall with WB refresh of rs2
    bus.i_wb_wen = 0; bus.i_wb_addr = '0; bus.i_wb_data = '0;
    bus.i_valid = 1; bus.i_pc = 32'h200; bus.i_imm = 32'h44;
    bus.i_rs1_addr = 5'd3; bus.i_rs1_data = 32'h3333;
    bus.i_rs2_addr = 5'd7; bus.i_rs2_data = 32'h7777;
    bus.i_rd_addr = 5'd9; bus.i_ctrl = 16'h1234;
    tick();
    chk("pre_stall_rs2", bus.o_rs2_data, 32'h7777);
    bus.i_stall = 1;
    bus.i_pc = 32'hDEAD; bus.i_rs1_data = 32'h9999; bus.i_rs2_data = 32'h8888;
    bus.i_rd_addr = 5'd2; bus.i_ctrl = 16'h5555;
    tick();
    bus.i_wb_wen = 1; bus.i_wb_addr = 5'd7; bus.i_wb_data = 32'hBEEF;
    tick();
    chk("stall_refresh_rs2", bus.o_rs2_data, 32'hBEEF);
    bus.i_wb_wen = 0; bus.i_wb_addr = '0; bus.i_wb_data = 32'h0BAD;
    tick();
    chk("stall_rs2_held", bus.o_rs2_data, 32'hBEEF);
    chk("stall_rs1_held", bus.o_rs1_data, 32'h3333);
    chk("stall_pc_held", bus.o_pc, 32'h200);
    chk("stall_rd_held", {27'd0, bus.o_rd_addr}, 32'd9);
    chk("stall_ctrl_held", {16'd0, bus.o_ctrl}, 32'h1234);
    chk("stall_cnt3", {28'd0, bus.o_stall_cnt}, 32'd3);

    // 4. flush beats stall
    bus.i_flush = 1; bus.i_ctrl = 16'hFFFF; bus.i_rd_addr = 5'h1F;
    tick();
    chk("flush_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("flush_ctrl", {16'd0, bus.o_ctrl}, 32'd0);
    chk("flush_rd", {27'd0, bus.o_rd_addr}, 32'd0);
    chk("flush_pc", bus.o_pc, 32'd0);
    chk("flush_cnt1", {28'd0, bus.o_flush_cnt}, 32'd1);
    chk("flush_stall_cnt", {28'd0, bus.o_stall_cnt}, 32'd3);

    // 5. bubble
    bus.i_flush = 0; bus.i_stall = 0; bus.i_valid = 0; bus.i_ctrl = 16'h00FF;
    bus.i_pc = 32'h300;
    tick();
    chk("bubble_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("bubble_ctrl", {16'd0, bus.o_ctrl}, 32'd0);
    chk("bubble_pc", bus.o_pc, 32'h300);

    // 6. counter saturation then asynchronous reset between edges
    bus.i_valid = 1; bus.i_pc = 32'h400; bus.i_ctrl = 16'h0042;
    tick();
    bus.i_stall = 1;
    for (int i = 0; i < 11; i++) tick();
    chk("stall_cnt14", {28'd0, bus.o_stall_cnt}, 32'd14);
    tick();
    chk("stall_cnt15", {28'd0, bus.o_stall_cnt}, 32'd15);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_cnt_sat", {28'd0, bus.o_stall_cnt}, 32'd15);
    chk("sat_pc_held", bus.o_pc, 32'h400);

    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall_cnt", {28'd0, bus.o_stall_cnt}, 32'd0);
    chk("arst_flush_cnt", {28'd0, bus.o_flush_cnt}, 32'd0);
    chk("arst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("arst_pc", bus.o_pc, 32'd0);
    chk("arst_ctrl", {16'd0, bus.o_ctrl}, 32'd0);
    #1 rst_n = 1'b1;
    bus.i_stall = 0; bus.i_pc = 32'h500; bus.i_rd_addr = 5'd4;
    tick();
    chk("post_rst_pc", bus.o_pc, 32'h500);
    chk("post_rst_rd", {27'd0, bus.o_rd_addr}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register for the 5-stage RV32 core.
- Captures the decode bundle and both regfile read-port values (rs1/rs2) at the clock edge and presents them to EX.
- Applies a write-first bypass from WB. The regfile updates on the same edge it is read, so without the bypass ID would latch stale data.
- Supports stall, flush and bubble insertion, refreshes held operands on WB writes during a stall, and keeps saturating stall/flush event counters for debug.

Parameters:
- DATA_WIDTH, 32, datapath width (PC, immediate, operands).
- ADDR_WIDTH, 5, register address width.
- CTRL_WIDTH, 16, width of the opaque decoded control bundle.
- CNT_WIDTH, 16, width of the event counters.

Ports:
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_stall  in  1  hold current contents (from hazard unit).
- i_flush  in  1  squash; load a bubble (branch/jump redirect).
- i_valid  in  1  ID holds a real instruction.
- i_pc  in  DATA_WIDTH  instruction PC.
- i_imm  in  DATA_WIDTH  sign-extended immediate.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  ADDR_WIDTH  register addresses.
- i_rs1_data, i_rs2_data  in  DATA_WIDTH  regfile read-port outputs.
- i_ctrl  in  CTRL_WIDTH  decoded control bundle.
- i_wb_wen  in  1  WB write enable (same signal that drives the regfile write enable).
- i_wb_addr  in  ADDR_WIDTH  WB destination register.
- i_wb_data  in  DATA_WIDTH  WB write data.
- o_valid  out  1  EX holds a real instruction.
- o_pc, o_imm  out  DATA_WIDTH  registered PC and immediate.
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  ADDR_WIDTH  registered register addresses.
- o_rs1_data, o_rs2_data  out  DATA_WIDTH  registered operands, bypass applied.
- o_ctrl  out  CTRL_WIDTH  registered control bundle; all zeros for a bubble.
- o_stall_cnt, o_flush_cnt  out  CNT_WIDTH  saturating event counters.

Behaviour:
- Reset (i_rst_n=0, asynchronous): every output goes to 0 immediately; counters clear.
- Per-edge priority: flush > stall > load.
- Flush:
  - o_valid<=0, o_ctrl<=0, o_rd_addr<=0.
  - Other data fields are don't-care; the implementation must drive 0.
  - o_flush_cnt+1. Flush overrides a simultaneous stall; o_stall_cnt is not incremented in that case.
- Stall (no flush):
  - All fields hold. o_stall_cnt+1.
  - Exception: if o_valid=1, i_wb_wen=1, i_wb_addr!=0 and i_wb_addr==o_rs1_addr, then o_rs1_data<=i_wb_data. Same rule for rs2, independently. This prevents a stalled instruction from losing a WB value that drains while it waits.
- Load (no flush, no stall):
  - o_valid<=i_valid.
  - o_pc, o_imm and addresses <= inputs.
  - o_ctrl<=i_ctrl if i_valid else 0.
  - o_rs1_data <= i_wb_data if (i_wb_wen && i_wb_addr!=0 && i_wb_addr==i_rs1_addr), else i_rs1_data. Same rule for rs2.
  - rs addr 0 always yields 0, whatever i_rs*_data or WB.
- Latency: one cycle, ID inputs to EX outputs.
- Counters saturate at all-ones, with no wrap.
- Bypass needs no i_valid qualification on WB beyond i_wb_wen. x0 writes are never bypassed.
- Single always block per register group.
- Reset asserted mid-stall or mid-flush clears immediately. First load occurs at the first rising edge after deassertion.

Test Plan:
1. Reset: hold i_rst_n=0 with random inputs toggling -> all outputs 0. Release, load i_pc=0x100, i_valid=1, i_rs1_data=0x11 -> next edge o_pc=0x100, o_valid=1, o_rs1_data=0x11.
2. WB bypass: i_rs1_addr=5, i_rs1_data=0xAAAA, i_wb_wen=1, i_wb_addr=5, i_wb_data=0x1234 -> o_rs1_data=0x1234. Repeat with i_wb_addr=0 and i_rs1_addr=0 -> o_rs1_data=0.
3. Stall refresh: stage holds rs2_addr=7. Assert i_stall for 3 cycles, with WB writing x7=0xBEEF in cycle 2 -> o_rs2_data=0xBEEF thereafter, other fields unchanged, o_stall_cnt=3.
4. Flush priority: i_stall=1 and i_flush=1 on the same edge, i_ctrl=0xFFFF -> o_valid=0, o_ctrl=0, o_rd_addr=0, o_flush_cnt=1, o_stall_cnt unchanged.
5. Bubble: i_valid=0, i_ctrl=0x00FF -> o_valid=0, o_ctrl=0.
6. Saturation and async reset: with CNT_WIDTH=4, stall for 20 cycles -> o_stall_cnt=15. Pulse i_rst_n low between edges -> counters and outputs clear before the next edge.
